// File: rtl/maincpu_pkg.sv
// Shared types and constants for the main-CPU program ROM controller.
package maincpu_pkg;

    localparam int unsigned ROM_AW = 15;
    localparam int unsigned DW     = 8;

    localparam logic [DW-1:0] OPEN_BUS_DEFAULT = 8'hFF;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StCapt,
        StAck
    } rom_state_e;

    // The ROM is 32 KB aligned, so the window is decided by address bit 15 alone.
    function automatic logic rom_window_hit(input logic addr_msb, input logic base_msb);
        return addr_msb == base_msb;
    endfunction

endpackage

// File: rtl/rom_lasthit_cache.sv
// One-entry last-read cache for the program ROM; only built when
// MAINCPU_ROM_LASTHIT_EN is defined.
`ifdef MAINCPU_ROM_LASTHIT_EN
module rom_lasthit_cache
    import maincpu_pkg::*;
(
    input  logic              clka,
    input  logic              rst_n,
    input  logic [ROM_AW-1:0] lookup_tag,
    output logic              lookup_hit,
    output logic [DW-1:0]     lookup_data,
    input  logic              fill_en,
    input  logic [ROM_AW-1:0] fill_tag,
    input  logic [DW-1:0]     fill_data
);

    logic [ROM_AW-1:0] tag_q;
    logic [DW-1:0]     data_q;
    logic              valid_q;

    // Only the valid bit needs reset; tag and data are qualified by it.
    always_ff @(posedge clka) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
        end else if (fill_en) begin
            valid_q <= 1'b1;
        end
    end

    always_ff @(posedge clka) begin
        if (fill_en) begin
            tag_q  <= fill_tag;
            data_q <= fill_data;
        end
    end

    always_comb begin
        lookup_hit  = valid_q && (tag_q == lookup_tag);
        lookup_data = data_q;
    end

endmodule
`endif

// File: rtl/maincpu_rom_ctrl.sv
// Bus-side controller for the main-CPU program ROM: window decode, BRAM latency
// absorption, one-cycle ack. Optional last-read cache via MAINCPU_ROM_LASTHIT_EN.
module maincpu_rom_ctrl
    import maincpu_pkg::*;
#(
    parameter int unsigned     ROM_LATENCY = 1,
    parameter logic [15:0]     ROM_BASE    = 16'h0000,
    parameter logic [DW-1:0]   OPEN_BUS    = OPEN_BUS_DEFAULT
) (
    input  logic              clka,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [15:0]       cpu_addr,
    output logic [DW-1:0]     cpu_data,
    output logic              cpu_ack,
    output logic              cpu_err,
    output logic [ROM_AW-1:0] addra,
    input  logic [DW-1:0]     douta,
    output logic              busy
);

    localparam logic [1:0] LAT_INIT = 2'(ROM_LATENCY);

    rom_state_e state;
    logic [1:0] cnt;
    logic       win_hit;
    logic       cache_hit;
    logic [DW-1:0] cache_data;

    assign win_hit = rom_window_hit(cpu_addr[15], ROM_BASE[15]);
    assign busy    = (state != StIdle);

`ifdef MAINCPU_ROM_LASTHIT_EN
    rom_lasthit_cache u_cache (
        .clka        (clka),
        .rst_n       (rst_n),
        .lookup_tag  (cpu_addr[ROM_AW-1:0]),
        .lookup_hit  (cache_hit),
        .lookup_data (cache_data),
        .fill_en     (state == StCapt),
        .fill_tag    (addra),
        .fill_data   (douta)
    );
`else
    assign cache_hit  = 1'b0;
    assign cache_data = '0;
`endif

    always_ff @(posedge clka) begin
        if (!rst_n) begin
            state    <= StIdle;
            addra    <= '0;
            cpu_data <= '0;
            cpu_ack  <= 1'b0;
            cpu_err  <= 1'b0;
            cnt      <= '0;
        end else begin
            cpu_ack <= 1'b0;
            cpu_err <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (cpu_req) begin
                        if (cpu_we) begin
                            state   <= StAck;
                            cpu_ack <= 1'b1;
                            cpu_err <= win_hit;
                        end else if (!win_hit) begin
                            state    <= StAck;
                            cpu_ack  <= 1'b1;
                            cpu_data <= OPEN_BUS;
                        end else if (cache_hit) begin
                            state    <= StAck;
                            cpu_ack  <= 1'b1;
                            cpu_data <= cache_data;
                        end else begin
                            addra <= cpu_addr[ROM_AW-1:0];
                            cnt   <= LAT_INIT;
                            state <= StWait;
                        end
                    end
                end
                StWait: begin
                    cnt <= cnt - 2'd1;
                    if (cnt == 2'd1) begin
                        state <= StCapt;
                    end
                end
                StCapt: begin
                    cpu_data <= douta;
                    cpu_ack  <= 1'b1;
                    state    <= StAck;
                end
                StAck: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule
